// File: rtl/ex_div.sv
// Multi-cycle 32-bit divide/remainder unit for the EX stage.
// Restoring division at one quotient bit per cycle. The pipeline is stalled while it runs.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wen_o,
  output logic        ready_o,
  output logic        hold_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_q, neg_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        is_signed;
  logic [31:0] abs1, abs2;
  logic [32:0] rem_shift, diff;
  logic        step_ok;
  logic [31:0] rem_next, quot_next, mag;

  // A 33-bit partial remainder is enough: 0x80000000 negates to itself and is read as 2^31.
  always_comb begin
    is_signed = ~op_i[0];
    abs1      = (is_signed && op1_i[31]) ? (~op1_i + 32'd1) : op1_i;
    abs2      = (is_signed && op2_i[31]) ? (~op2_i + 32'd1) : op2_i;
    rem_shift = {rem_q, dividend_q[31]};
    diff      = rem_shift - {1'b0, divisor_q};
    step_ok   = ~diff[32];
    rem_next  = step_ok ? diff[31:0] : rem_shift[31:0];
    quot_next = {quot_q[30:0], step_ok};
    mag       = is_rem_q ? rem_next : quot_next;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    is_rem_d   = is_rem_q;
    neg_d      = neg_q;
    rd_d       = rd_q;
    result_d   = 32'd0;
    ready_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          is_rem_d   = op_i[1];
          rd_d       = rd_addr_i;
          dividend_d = abs1;
          divisor_d  = abs2;
          quot_d     = 32'd0;
          rem_d      = 32'd0;
          cnt_d      = 6'd0;
          neg_d      = op_i[1] ? (is_signed & op1_i[31])
                               : (is_signed & (op1_i[31] ^ op2_i[31]));
          if (op2_i == 32'd0) begin
            state_d  = StDone;
            ready_d  = 1'b1;
            result_d = op_i[1] ? op1_i : 32'hFFFF_FFFF;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          dividend_d = {dividend_q[30:0], 1'b0};
          rem_d      = rem_next;
          quot_d     = quot_next;
          cnt_d      = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = StDone;
            ready_d  = 1'b1;
            result_d = neg_q ? (~mag + 32'd1) : mag;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      is_rem_q   <= 1'b0;
      neg_q      <= 1'b0;
      rd_q       <= 5'd0;
      result_q   <= 32'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      is_rem_q   <= is_rem_d;
      neg_q      <= neg_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // A flush during DONE suppresses the write-back.
  assign ready_o   = ready_q & ~flush_i;
  assign reg_wen_o = ready_q & ~flush_i;
  assign result_o  = result_q;
  assign rd_addr_o = ready_q ? rd_q : 5'd0;
  assign hold_o    = ~rst & (((state_q == StIdle) & start_i & ~flush_i) | (state_q == StCalc));

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 Port start_i, input, 1 bit: a decoded divide/remainder instruction is present at the EX input this cycle.
REQ-005 Port op_i, input, 2 bits: operation select. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 Port op1_i, input, 32 bits: dividend.
REQ-007 Port op2_i, input, 32 bits: divisor.
REQ-008 Port rd_addr_i, input, 5 bits: destination register of the instruction.
REQ-009 Port flush_i, input, 1 bit: pipeline flush (taken jump/branch); aborts any operation in progress.
REQ-010 Port result_o, output, 32 bits: quotient or remainder; valid only when ready_o=1.
REQ-011 Port rd_addr_o, output, 5 bits: latched destination register.
REQ-012 Port reg_wen_o, output, 1 bit: register-file write enable; a one-cycle pulse coincident with ready_o.
REQ-013 Port ready_o, output, 1 bit: the result is valid this cycle.
REQ-014 Port hold_o, output, 1 bit: stall request to the upstream pipeline registers and PC.

Function
REQ-015 The block SHALL implement states IDLE, CALC and DONE.
REQ-016 In IDLE with start_i=1 and flush_i=0, the block SHALL latch op_i, rd_addr_i and the operand magnitudes, and SHALL set the result sign.
- Signed ops: the quotient is negative iff the operand signs differ; the remainder sign follows the dividend.
- Transition: to CALC if op2_i≠0; to DONE if op2_i=0.
REQ-017 In CALC the block SHALL perform unsigned restoring division at one quotient bit per cycle, MSB first, for exactly 32 cycles using a 6-bit counter, then move to DONE.
REQ-018 Latency from the start_i cycle to the ready_o cycle SHALL be 33 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-019 In DONE the block SHALL assert ready_o=1 and reg_wen_o=1 for exactly one cycle, present result_o after sign correction, then return to IDLE.
REQ-020 A zero divisor SHALL give quotient 0xFFFFFFFF and remainder equal to op1_i, for both signed and unsigned ops.
REQ-021 Signed overflow (op1_i=0x80000000, op2_i=0xFFFFFFFF) SHALL give DIV=0x80000000 and REM=0x00000000.
REQ-022 The magnitude of 0x80000000 SHALL be treated as unsigned 2^31; no extra datapath width beyond 32+1 bits SHALL be required.
REQ-023 hold_o SHALL be asserted in the following cases, and low otherwise, including in DONE:
- combinationally when state=IDLE and start_i=1 and flush_i=0;
- for every CALC cycle.
REQ-024 start_i SHALL be ignored outside IDLE.
REQ-025 A flush_i=1 in CALC or DONE SHALL force IDLE on the next edge with ready_o=0 and reg_wen_o=0; no write SHALL occur.
REQ-026 flush_i=1 together with start_i in IDLE SHALL prevent the operation from starting.
REQ-027 Outside DONE: result_o=0, rd_addr_o=0, ready_o=0, reg_wen_o=0.

Reset
REQ-028 On rst=1, regardless of clock, the block SHALL go to state IDLE and clear the counter, dividend, divisor, quotient and remainder registers.
REQ-029 While rst=1, all outputs SHALL be 0, including hold_o.
REQ-030 Reset asserted mid-CALC SHALL abort the operation without a write.
REQ-031 After rst deasserts, the next start_i SHALL begin a fresh operation.

Verification
REQ-032 DIVU: op1=100, op2=7, rd=5 -> hold_o high 33 cycles; ready_o and reg_wen_o pulse at cycle 33; result_o=14; rd_addr_o=5.
REQ-033 REM and DIV sign cases:
- REM op1=-7 (0xFFFFFFF9), op2=2 -> result 0xFFFFFFFF (-1).
- DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-034 Divide by zero:
- DIV op1=0x12345678, op2=0 -> ready at cycle 1, result 0xFFFFFFFF.
- REMU with the same operands -> 0x12345678.
REQ-035 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-036 Abort cases:
- flush_i pulse at CALC cycle 10 -> IDLE on the next cycle, hold_o low, no reg_wen_o pulse.
- A new start_i 2 cycles later -> completes normally.
REQ-037 rst asserted mid-CALC with no clock edge -> all outputs 0 immediately; start_i held high during CALC is ignored (exactly one ready_o pulse results).
